cnt_param: RTL and testbench
============================

# cnt_param

Parametrised prescaled up/down counter for general timing and event counting in the cell library. It generalises the fixed 16-bit wrap counter with:
- configurable width, runtime terminal value, direction and terminal mode (wrap, saturate, one-shot);
- synchronous load and clear;
- a built-in prescaler, a terminal-count pulse and a sticky overflow flag.

It sits beside control FSMs as their timeout/interval source.

## Interface
- WIDTH, 16, counter width; legal range 2..32
- PRESC_W, 8, prescaler width
- mclk  in  1  clock
- mreset_n  in  1  reset, asynchronous, active-low
- en  in  1  count enable; gates prescaler
- clr  in  1  synchronous clear
- ld  in  1  synchronous load of ld_val
- ld_val  in  WIDTH  load value
- dir  in  1  1 = up, 0 = down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- term_val  in  WIDTH  up-count terminal / down-count reload value
- presc  in  PRESC_W  step every presc+1 enabled cycles
- ovf_clr  in  1  clears ovf
- cnt  out  WIDTH  current count
- tc  out  1  one-cycle terminal-count pulse
- ovf  out  1  sticky; set by every tc
- halted  out  1  counter stopped in HALT state

## Operation
- Reset: all of the following are 0 and the state is RUN: cnt, tc, ovf, halted, prescaler count pcnt.
- Priority, highest first: reset, clr, ld, tick.
- clr: cnt=0, pcnt=0, state RUN, tc=0.
- ld: cnt=ld_val, pcnt=0, state RUN, tc=0. ld_val is not range-checked.
- Tick generation:
  - tick = en && state==RUN && pcnt==presc.
  - On a tick, pcnt returns to 0. Otherwise pcnt increments when en, and holds when !en.
  - presc=0 gives a tick every enabled cycle.
- Terminal condition on a tick:
  - Up: terminal when cnt >= term_val, compared unsigned against the live term_val.
  - Down: terminal when cnt == 0.
- Non-terminal tick: cnt ±1.
- Terminal tick:
  - tc=1 for the next cycle and ovf=1.
  - wrap: up → 0; down → term_val.
  - saturate: cnt holds; state becomes HALT.
  - one-shot: cnt takes the wrap value; state becomes HALT.
- State machine: RUN ↔ HALT.
  - RUN→HALT only on a terminal tick in saturate or one-shot mode.
  - HALT→RUN only via clr or ld.
  - In HALT: cnt and pcnt are frozen; en, dir and mode changes are ignored.
  - halted = (state==HALT).
- ovf: cleared by ovf_clr. If set and clear coincide, set wins.
- mode, dir and term_val are sampled at each tick, so a change mid-count takes effect at the next tick.
- Up mode with cnt > term_val (after ld or a term_val change) is terminal on the next tick.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- en rising with presc=0: cnt updates at the first edge where en=1 is sampled.
- With presc=P and en held high: one step per P+1 cycles. The first step happens P+1 edges after clr/ld.
- tc is high exactly one cycle, coincident with cnt showing the post-terminal value.
- Saturate mode: a single tc on entering HALT; no repeats while halted.
- clr or ld in the same cycle as a terminal tick: clr/ld wins; no tc and no ovf set.
- Reset asserted mid-operation: immediate return to reset values, independent of mclk.

## Structure
- Shared package cnt_pkg:
  - mode encodings: CNT_WRAP, CNT_SAT, CNT_ONESHOT;
  - state typedef RUN/HALT;
  - WIDTH range limits.
- One sub-module, cnt_presc: takes en, presc, restart and freeze, and produces the tick. It is reusable by other timers.
- The counter datapath and FSM stay in cnt_param.

## Test plan
- Reset with en=1, presc=0 → all outputs 0. Release → cnt counts 1, 2, 3 on successive edges.
- WIDTH=8, term_val=5, up, wrap, presc=0 → cnt 0..5, 0. tc high only with cnt=0 after 5; ovf=1. Pulse ovf_clr on the same cycle as a later tc → ovf stays 1.
- Down, saturate, ld_val=3 → 2, 1, 0; tc once; halted=1; cnt stays 0 for 20 cycles with en=1. Then ld 7 → halted=0, counts 6.
- One-shot, up, term_val=3, presc=2 → steps every 3 cycles: 1, 2, 3, then 0 with tc, halted=1. clr → RUN, cnt=0, next step 3 cycles later.
- up, cnt=9, term_val changed to 4 → next tick wraps to 0 with tc. Simultaneous clr and terminal tick → cnt=0, tc=0, ovf unchanged.
- en toggled 1, 0, 1 with presc=3 → step only after 4 enabled cycles. Async reset mid-count → immediate 0 on every output.

Source files
------------

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared encodings and limits for the parametrised counter family.
package cnt_pkg;
   typedef enum logic [1:0] {
      CNT_WRAP    = 2'b00,
      CNT_SAT     = 2'b01,
      CNT_ONESHOT = 2'b10
   } cnt_mode_e;
   typedef enum logic {RUN = 1'b0, HALT = 1'b1} cnt_state_e;
   localparam int CNT_WIDTH_MIN = 2;
   localparam int CNT_WIDTH_MAX = 32;
endpackage

// File: rtl/cnt_presc.sv
// cnt_presc: enabled-cycle prescaler producing a tick every presc+1 enabled cycles.
module cnt_presc #(
   parameter int PRESC_W = 8
) (
   input  logic               mclk,
   input  logic               mreset_n,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   input  logic               restart,
   input  logic               freeze,
   output logic               tick
);
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   assign tick = en && !freeze && (pcnt_q == presc);
   always_comb begin
      pcnt_d = restart ? '0 : (freeze || !en) ? pcnt_q : tick ? '0 : pcnt_q + 1'b1;
   end
   always_ff @(posedge mclk or negedge mreset_n) begin
      if (!mreset_n) pcnt_q <= '0;
      else           pcnt_q <= pcnt_d;
   end
endmodule

// File: rtl/cnt_param.sv
// cnt_param: prescaled up/down counter with wrap, saturate and one-shot terminal modes.
// Terminal handling uses the live term_val/dir/mode sampled at each tick.
module cnt_param #(
   parameter int WIDTH   = 16,
   parameter int PRESC_W = 8
) (
   input  logic               mclk,
   input  logic               mreset_n,
   input  logic               en,
   input  logic               clr,
   input  logic               ld,
   input  logic [WIDTH-1:0]   ld_val,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   term_val,
   input  logic [PRESC_W-1:0] presc,
   input  logic               ovf_clr,
   output logic [WIDTH-1:0]   cnt,
   output logic               tc,
   output logic               ovf,
   output logic               halted
);
   import cnt_pkg::*;
   if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
      $error("cnt_param: WIDTH out of range");
   end
   cnt_state_e       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d, ovf_q, ovf_d;
   logic             tick, term, stop;
   logic [WIDTH-1:0] wrap_val;
   cnt_presc #(.PRESC_W(PRESC_W)) u_presc (
      .mclk     (mclk),
      .mreset_n (mreset_n),
      .en       (en),
      .presc    (presc),
      .restart  (clr || ld),
      .freeze   (state_q == HALT),
      .tick     (tick)
   );
   assign term     = dir ? (cnt_q >= term_val) : (cnt_q == '0);
   assign wrap_val = dir ? '0 : term_val;
   assign stop     = (mode == CNT_SAT) || (mode == CNT_ONESHOT);
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q && !ovf_clr;
      if (clr) begin
         cnt_d   = '0;
         state_d = RUN;
      end else if (ld) begin
         cnt_d   = ld_val;
         state_d = RUN;
      end else if (tick && term) begin
         tc_d    = 1'b1;
         ovf_d   = 1'b1;
         cnt_d   = (mode == CNT_SAT) ? cnt_q : wrap_val;
         state_d = stop ? HALT : RUN;
      end else if (tick) begin
         cnt_d = dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
   end
   always_ff @(posedge mclk or negedge mreset_n) begin
      if (!mreset_n) begin
         cnt_q   <= '0;
         state_q <= RUN;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end
   assign cnt    = cnt_q;
   assign tc     = tc_q;
   assign ovf    = ovf_q;
   assign halted = (state_q == HALT);
endmodule

// File: tb/tb_cnt_param.sv
// tb_cnt_param: directed scenarios for cnt_param with hand-computed expectations.
module tb_cnt_param;
   logic       mclk = 1'b0;
   logic       mreset_n, en, clr, ld, dir, ovf_clr;
   logic [7:0] ld_val, term_val, presc, cnt;
   logic [1:0] mode;
   logic       tc, ovf, halted;
   int         n_checks = 0;
   int         n_fail = 0;

   cnt_param #(.WIDTH(8), .PRESC_W(8)) dut (
      .mclk(mclk), .mreset_n(mreset_n), .en(en), .clr(clr), .ld(ld), .ld_val(ld_val),
      .dir(dir), .mode(mode), .term_val(term_val), .presc(presc), .ovf_clr(ovf_clr),
      .cnt(cnt), .tc(tc), .ovf(ovf), .halted(halted)
   );

   always #5 mclk = ~mclk;

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic test_reset();
      mreset_n = 1'b0; en = 1'b1; clr = 1'b0; ld = 1'b0; ld_val = 8'd0; dir = 1'b1;
      mode = 2'b00; term_val = 8'hFF; presc = 8'd0; ovf_clr = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({cnt, tc, ovf, halted} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_vals: cnt=%0d tc=%b ovf=%b halted=%b, expected all 0", cnt, tc, ovf, halted);
      end
      mreset_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         n_checks++;
         if (cnt !== 8'(i)) begin
            n_fail++;
            $display("FAIL reset_count: cnt=%0d expected %0d", cnt, i);
         end
      end
   endtask

   task automatic test_wrap();
      term_val = 8'd5; dir = 1'b1; mode = 2'b00; presc = 8'd0;
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         n_checks++;
         if (cnt !== 8'(i) || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_count: cnt=%0d tc=%b expected cnt=%0d tc=0", cnt, tc, i);
         end
      end
      step();
      n_checks++;
      if (cnt !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_terminal: cnt=%0d tc=%b ovf=%b expected cnt=0 tc=1 ovf=1", cnt, tc, ovf);
      end
      repeat (5) step();
      n_checks++;
      if (cnt !== 8'd5 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_second: cnt=%0d tc=%b expected cnt=5 tc=0", cnt, tc);
      end
      ovf_clr = 1'b1;
      step();
      n_checks++;
      if (cnt !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set_wins: cnt=%0d tc=%b ovf=%b expected cnt=0 tc=1 ovf=1", cnt, tc, ovf);
      end
      step();
      ovf_clr = 1'b0;
      n_checks++;
      if (ovf !== 1'b0 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: ovf=%b tc=%b expected ovf=0 tc=0", ovf, tc);
      end
   endtask

   task automatic test_saturate();
      int tc_seen;
      dir = 1'b0; mode = 2'b01; term_val = 8'd9; ld_val = 8'd3;
      ld = 1'b1; step(); ld = 1'b0;
      for (int i = 2; i >= 0; i--) begin
         step();
         n_checks++;
         if (cnt !== 8'(i) || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_count: cnt=%0d tc=%b expected cnt=%0d tc=0", cnt, tc, i);
         end
      end
      step();
      n_checks++;
      if (cnt !== 8'd0 || tc !== 1'b1 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_enter_halt: cnt=%0d tc=%b halted=%b expected 0 1 1", cnt, tc, halted);
      end
      tc_seen = 0;
      for (int i = 0; i < 20; i++) begin
         dir = i[0];
         step();
         if (tc === 1'b1 || cnt !== 8'd0 || halted !== 1'b1) tc_seen++;
      end
      dir = 1'b0;
      n_checks++;
      if (tc_seen !== 0) begin
         n_fail++;
         $display("FAIL sat_frozen: %0d bad cycles while halted, expected 0", tc_seen);
      end
      ld_val = 8'd7; ld = 1'b1; step(); ld = 1'b0;
      n_checks++;
      if (cnt !== 8'd7 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_reload: cnt=%0d halted=%b expected cnt=7 halted=0", cnt, halted);
      end
      step();
      n_checks++;
      if (cnt !== 8'd6) begin
         n_fail++;
         $display("FAIL sat_resume: cnt=%0d expected 6", cnt);
      end
   endtask

   task automatic test_oneshot();
      dir = 1'b1; mode = 2'b10; term_val = 8'd3; presc = 8'd2;
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         repeat (2) step();
         n_checks++;
         if (cnt !== 8'(i - 1)) begin
            n_fail++;
            $display("FAIL os_hold: cnt=%0d expected %0d", cnt, i - 1);
         end
         step();
         n_checks++;
         if (cnt !== 8'(i)) begin
            n_fail++;
            $display("FAIL os_step: cnt=%0d expected %0d", cnt, i);
         end
      end
      repeat (3) step();
      n_checks++;
      if (cnt !== 8'd0 || tc !== 1'b1 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL os_terminal: cnt=%0d tc=%b halted=%b expected 0 1 1", cnt, tc, halted);
      end
      repeat (6) step();
      n_checks++;
      if (cnt !== 8'd0 || halted !== 1'b1 || tc !== 1'b0) begin
         n_fail++;
         $display("FAIL os_stays: cnt=%0d halted=%b tc=%b expected 0 1 0", cnt, halted, tc);
      end
      clr = 1'b1; step(); clr = 1'b0;
      n_checks++;
      if (cnt !== 8'd0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL os_clr: cnt=%0d halted=%b expected 0 0", cnt, halted);
      end
      repeat (2) step();
      n_checks++;
      if (cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL os_restart_hold: cnt=%0d expected 0", cnt);
      end
      step();
      n_checks++;
      if (cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL os_restart_step: cnt=%0d expected 1", cnt);
      end
   endtask

   task automatic test_term_change();
      mode = 2'b00; dir = 1'b1; presc = 8'd0; term_val = 8'hFF; ld_val = 8'd9;
      ld = 1'b1; step(); ld = 1'b0;
      term_val = 8'd4;
      step();
      n_checks++;
      if (cnt !== 8'd0 || tc !== 1'b1) begin
         n_fail++;
         $display("FAIL term_change: cnt=%0d tc=%b expected cnt=0 tc=1", cnt, tc);
      end
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      repeat (3) step();
      n_checks++;
      if (cnt !== 8'd4 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_clr: cnt=%0d ovf=%b expected cnt=4 ovf=0", cnt, ovf);
      end
      clr = 1'b1; step(); clr = 1'b0;
      n_checks++;
      if (cnt !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_beats_tc: cnt=%0d tc=%b ovf=%b expected 0 0 0", cnt, tc, ovf);
      end
   endtask

   task automatic test_en_toggle();
      presc = 8'd3; term_val = 8'hFF; dir = 1'b1; mode = 2'b00;
      clr = 1'b1; step(); clr = 1'b0;
      en = 1'b1; step();
      en = 1'b0; repeat (2) step();
      en = 1'b1; repeat (2) step();
      n_checks++;
      if (cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL en_gated: cnt=%0d expected 0 after 3 enabled cycles", cnt);
      end
      step();
      n_checks++;
      if (cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL en_step: cnt=%0d expected 1 after 4 enabled cycles", cnt);
      end
   endtask

   task automatic test_async_reset();
      presc = 8'd0; term_val = 8'd2; mode = 2'b01;
      repeat (2) step();
      n_checks++;
      if (cnt !== 8'd2 || halted !== 1'b1 || tc !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL async_pre: cnt=%0d tc=%b ovf=%b halted=%b expected 2 1 1 1", cnt, tc, ovf, halted);
      end
      #1 mreset_n = 1'b0;
      #1;
      n_checks++;
      if ({cnt, tc, ovf, halted} !== 11'd0) begin
         n_fail++;
         $display("FAIL async_reset: cnt=%0d tc=%b ovf=%b halted=%b expected all 0", cnt, tc, ovf, halted);
      end
      step();
      mreset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_saturate();
      test_oneshot();
      test_term_change();
      test_en_toggle();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
